// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
//   UART_DEPTH  : default receive FIFO depth (entries)
//   UART_BYTE_W : width of one received character
//   UART_PTR_W  : pointer width matching UART_DEPTH
//   ptr_width() : pointer width for an arbitrary power-of-two depth
package uart_pkg;

  localparam int unsigned UART_DEPTH  = 16;
  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned UART_PTR_W  = $clog2(UART_DEPTH);

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_DEPTH,
  parameter int unsigned WIDTH = UART_BYTE_W,
  parameter int unsigned AW    = UART_PTR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer between a UART receiver and a CPU: first-word-fall-through
// FIFO with sticky overflow flag and level interrupt.
//   i_Clock    : clock, rising edge
//   i_Rst_n    : asynchronous active-low reset
//   i_Rx_DV    : byte-valid pulse from the receiver
//   i_Rx_Byte  : received byte
//   i_Rd_En    : pop strobe for the head entry
//   i_Clr_Ovf  : clear sticky overflow
//   o_Rd_Data  : head byte (00 while empty)
//   o_Empty    : no entries
//   o_Full     : DEPTH entries
//   o_Count    : entry count, 0..DEPTH
//   o_Overflow : a byte was dropped since last clear
//   o_Irq      : count >= IRQ_LEVEL or overflow
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = UART_DEPTH,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic                           i_Clock,
  input  logic                           i_Rst_n,
  input  logic                           i_Rx_DV,
  input  logic [UART_BYTE_W-1:0]         i_Rx_Byte,
  input  logic                           i_Rd_En,
  input  logic                           i_Clr_Ovf,
  output logic [UART_BYTE_W-1:0]         o_Rd_Data,
  output logic                           o_Empty,
  output logic                           o_Full,
  output logic [ptr_width(DEPTH):0]      o_Count,
  output logic                           o_Overflow,
  output logic                           o_Irq
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic                   ovf;
  logic                   full;
  logic                   empty;
  logic                   do_push;
  logic                   do_pop;
  logic [UART_BYTE_W-1:0] ram_rdata;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when the same edge pops,
  // because the slot being freed is the one the write pointer lands on.
  // A pop on an empty FIFO is ignored even if a push arrives that edge.
  assign do_pop  = i_Rd_En && !empty;
  assign do_push = i_Rx_DV && (!full || do_pop);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
      // New overflow takes priority over a clear on the same edge.
      if (i_Rx_DV && full && !i_Rd_En) ovf <= 1'b1;
      else if (i_Clr_Ovf)              ovf <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (UART_BYTE_W),
    .AW    (PW)
  ) u_ram (
    .clk   (i_Clock),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (i_Rx_Byte),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign o_Rd_Data  = empty ? '0 : ram_rdata;
  assign o_Empty    = empty;
  assign o_Full     = full;
  assign o_Count    = count;
  assign o_Overflow = ovf;
  assign o_Irq      = (count >= (PW+1)'(IRQ_LEVEL)) || ovf;

endmodule
